// File: rtl/comparer_sync_if.sv
// Byte-stream bus into the sequence matcher: qualified byte in, per-byte match verdict back.
// The producer side uses master; the matcher uses slave.
interface comparer_sync_if;
   logic       load;
   logic [7:0] data;
   logic       resolve;
   logic       reject;

   modport master (
      output load,
      output data,
      input  resolve,
      input  reject
   );

   modport slave (
      input  load,
      input  data,
      output resolve,
      output reject
   );
endinterface

// File: rtl/comparer_sync.sv
// Sliding-window matcher: flags when the last L loaded bytes equal Ref.
// Verdict is combinational on the byte being loaded; unloaded cycles leave the window untouched.
module comparer_sync #(
   parameter int unsigned    L   = 3,
   parameter logic [8*L-1:0] Ref = "ABC"
) (
   input  logic           clock,
   input  logic           restart_n,
   comparer_sync_if.slave bus
);

   generate
      if (L == 1) begin : g_single
         // A single-byte reference needs no history; the clock is intentionally unused.
         logic unused_clock;
         logic match;

         assign unused_clock = clock;
         assign match        = (bus.data == Ref[7:0]);
         assign bus.resolve  = restart_n & bus.load & match;
         assign bus.reject   = restart_n & bus.load & ~match;
      end else begin : g_window
         localparam int unsigned    HW       = 8 * (L - 1);
         localparam int unsigned    CW       = $clog2(L);
         localparam logic [CW-1:0]  CNT_FULL = CW'(L - 1);

         logic [HW-1:0] hist_q, hist_d;
         logic [CW-1:0] cnt_q, cnt_d;
         logic          full;
         logic          match;

         assign full  = (cnt_q == CNT_FULL);
         assign match = full
                      & (hist_q == Ref[8*L-1:8])
                      & (bus.data == Ref[7:0]);

         always_comb begin
            hist_d = hist_q;
            cnt_d  = cnt_q;
            if (bus.load) begin
               hist_d = (hist_q << 8) | HW'(bus.data);
               if (!full) begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end

         // A byte loaded during restart seeds the fresh window rather than being dropped.
         always_ff @(posedge clock) begin
            if (!restart_n) begin
               hist_q <= bus.load ? HW'(bus.data) : '0;
               cnt_q  <= bus.load ? CW'(1) : '0;
            end else begin
               hist_q <= hist_d;
               cnt_q  <= cnt_d;
            end
         end

         assign bus.resolve = restart_n & bus.load & match;
         assign bus.reject  = restart_n & bus.load & full & ~match;
      end
   endgenerate

endmodule

// File: tb/tb_comparer_sync.sv
// Directed bench for comparer_sync: an L=3 "ABC" instance and an L=1 "Z" instance.
module tb_comparer_sync;
   logic clock = 1'b0;
   logic restart_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   comparer_sync_if bus3();
   comparer_sync_if bus1();

   comparer_sync #(.L(3), .Ref("ABC")) u_dut3 (
      .clock     (clock),
      .restart_n (restart_n),
      .bus       (bus3)
   );

   comparer_sync #(.L(1), .Ref("Z")) u_dut1 (
      .clock     (clock),
      .restart_n (restart_n),
      .bus       (bus1)
   );

   // Inputs change just after the rising edge; outputs are sampled on the falling edge.
   task automatic drive3(input logic rst_n, input logic ld, input logic [7:0] d);
      @(posedge clock);
      #1;
      restart_n = rst_n;
      bus3.load = ld;
      bus3.data = d;
      bus1.load = 1'b0;
      @(negedge clock);
   endtask

   task automatic drive1(input logic rst_n, input logic ld, input logic [7:0] d);
      @(posedge clock);
      #1;
      restart_n = rst_n;
      bus1.load = ld;
      bus1.data = d;
      bus3.load = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive3(1'b0, 1'b0, 8'h00);
         checks++;
         if (bus3.resolve !== 1'b0) begin
            errors++;
            $display("FAIL reset_resolve[%0d] got %b want 0", i, bus3.resolve);
         end
         checks++;
         if (bus3.reject !== 1'b0) begin
            errors++;
            $display("FAIL reset_reject[%0d] got %b want 0", i, bus3.reject);
         end
      end
   endtask

   task automatic test_basic();
      logic [7:0] d [4];
      logic       er [4];
      logic       ej [4];
      d  = '{"A", "B", "C", "D"};
      er = '{1'b0, 1'b0, 1'b1, 1'b0};
      ej = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         drive3(1'b1, 1'b1, d[i]);
         checks++;
         if (bus3.resolve !== er[i]) begin
            errors++;
            $display("FAIL basic_resolve[%0d] got %b want %b", i, bus3.resolve, er[i]);
         end
         checks++;
         if (bus3.reject !== ej[i]) begin
            errors++;
            $display("FAIL basic_reject[%0d] got %b want %b", i, bus3.reject, ej[i]);
         end
      end
   endtask

   task automatic test_interleaved();
      logic [7:0] d  [6];
      logic       ld [6];
      logic       er [6];
      d  = '{"A", "a", "B", "b", "C", "c"};
      ld = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      drive3(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) begin
         drive3(1'b1, ld[i], d[i]);
         checks++;
         if (bus3.resolve !== er[i]) begin
            errors++;
            $display("FAIL gap_resolve[%0d] got %b want %b", i, bus3.resolve, er[i]);
         end
         checks++;
         if (bus3.reject !== 1'b0) begin
            errors++;
            $display("FAIL gap_reject[%0d] got %b want 0", i, bus3.reject);
         end
      end
   endtask

   task automatic test_overlap();
      logic [7:0] d [17];
      logic       er, ej;
      d = '{"A", "B", "X", "C", "A", "B", "C", "A", "B", "C",
            "A", "B", "A", "B", "A", "B", "C"};
      drive3(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 17; i++) begin
         er = (i == 6) || (i == 9) || (i == 16);
         ej = (i >= 2) && !er;
         drive3(1'b1, 1'b1, d[i]);
         checks++;
         if (bus3.resolve !== er) begin
            errors++;
            $display("FAIL stream_resolve[%0d] got %b want %b", i + 1, bus3.resolve, er);
         end
         checks++;
         if (bus3.reject !== ej) begin
            errors++;
            $display("FAIL stream_reject[%0d] got %b want %b", i + 1, bus3.reject, ej);
         end
      end
   endtask

   task automatic test_restart_seed();
      logic [7:0] d  [9];
      logic       rn [9];
      logic       er [9];
      d  = '{"A", "B", "C", "A", "B", "C", "A", "B", "C"};
      rn = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      drive3(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 9; i++) begin
         drive3(rn[i], 1'b1, d[i]);
         checks++;
         if (bus3.resolve !== er[i]) begin
            errors++;
            $display("FAIL seed_resolve[%0d] got %b want %b", i, bus3.resolve, er[i]);
         end
         checks++;
         if (bus3.reject !== 1'b0) begin
            errors++;
            $display("FAIL seed_reject[%0d] got %b want 0", i, bus3.reject);
         end
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] d  [5];
      logic       rn [5];
      logic       ld [5];
      logic       er [5];
      logic       ej [5];
      d  = '{"Y", "Z", "Z", "Z", "Z"};
      rn = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      ld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      er = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      ej = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive1(rn[i], ld[i], d[i]);
         checks++;
         if (bus1.resolve !== er[i]) begin
            errors++;
            $display("FAIL single_resolve[%0d] got %b want %b", i, bus1.resolve, er[i]);
         end
         checks++;
         if (bus1.reject !== ej[i]) begin
            errors++;
            $display("FAIL single_reject[%0d] got %b want %b", i, bus1.reject, ej[i]);
         end
      end
   endtask

   task automatic test_held_restart();
      logic [7:0] d [3];
      d = '{"A", "B", "C"};
      for (int i = 0; i < 3; i++) begin
         drive3(1'b0, 1'b1, d[i]);
         checks++;
         if (bus3.resolve !== 1'b0) begin
            errors++;
            $display("FAIL held_resolve[%0d] got %b want 0", i, bus3.resolve);
         end
         checks++;
         if (bus3.reject !== 1'b0) begin
            errors++;
            $display("FAIL held_reject[%0d] got %b want 0", i, bus3.reject);
         end
      end
      // Only the last held-restart byte survives, so one more byte cannot fill the window.
      drive3(1'b1, 1'b1, "D");
      checks++;
      if (bus3.reject !== 1'b0) begin
         errors++;
         $display("FAIL held_after_reject got %b want 0", bus3.reject);
      end
      drive3(1'b1, 1'b1, "E");
      checks++;
      if (bus3.reject !== 1'b1) begin
         errors++;
         $display("FAIL held_full_reject got %b want 1", bus3.reject);
      end
   endtask

   initial begin
      restart_n = 1'b0;
      bus3.load = 1'b0;
      bus3.data = 8'h00;
      bus1.load = 1'b0;
      bus1.data = 8'h00;
      test_reset();
      test_basic();
      test_interleaved();
      test_overlap();
      test_restart_seed();
      test_single_byte();
      test_held_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/comparer_sync.md
Name: comparer_sync

Overview:
- Streaming byte-sequence matcher. Watches a byte stream qualified by a load strobe and flags when the most recent L loaded bytes equal the reference string Ref.
- The final reference byte is decided in the same cycle it is presented.
- Used as a keyword/header detector (e.g. message tag recognition) in serial-protocol parsers.
- Matching state is a sliding window of previously loaded bytes; non-loaded cycles are ignored.

Parameters:
- L, 3, reference string length in bytes (>= 1).
- Ref, "ABC", reference string, 8*L bits. Ref[8L-1:8L-8] is the first character; Ref[7:0] is the last.

Ports:
- clock  input  1  single clock, all state updates on rising edge.
- restart_n  input  1  reset, synchronous and active-low. It is the codebase's restart port with active-low polarity.
- load  input  1  data byte valid this cycle.
- data  input  8  stream byte.
- resolve  output  1  combinational. The current byte completes a match of Ref.
- reject  output  1  combinational. The current byte fills a complete window that does not match Ref.

Behaviour:
- State:
  - hist: L-1 byte shift register holding the last L-1 loaded bytes, newest at low end.
  - cnt: 0..L-1, saturating count of valid bytes in hist.
  - For L=1, hist and cnt are absent.
- Rising edge with restart_n=0 (synchronous reset):
  - load=1: hist cleared, then the current data becomes the newest entry; cnt <= 1 (0 when L=1). The byte seen during the restart cycle starts a new window.
  - load=0: hist cleared; cnt <= 0.
- Rising edge with restart_n=1, load=1: hist shifts in data, discarding the oldest entry; cnt <= min(cnt+1, L-1).
- Rising edge with restart_n=1, load=0: state holds. Gaps between loaded bytes do not break a match.
- resolve = restart_n & load & (cnt==L-1) & (hist == Ref[8L-1:8]) & (data == Ref[7:0]).
  - Combinational, zero latency. It asserts during the cycle the final byte is on the inputs, before the edge that samples it.
  - Overlapping matches are allowed (sliding window, no clear after a match).
- reject = restart_n & load & (cnt==L-1) & ~resolve.
- restart_n=0 forces resolve=0 and reject=0 in that cycle, even if the window would match.
- Reset values:
  - Outputs are 0 whenever restart_n=0 or load=0.
  - After reset with load=0: cnt=0, so neither output can assert until L-1 further bytes are loaded.
- Fewer than L-1 bytes loaded since reset: resolve=0 and reject=0.
- Comparison is exact 8-bit equality; no case folding.

Test Plan:
1. restart_n=0 two cycles (load=0), then load=1 with bytes A,B,C,D on consecutive cycles.
   - resolve=1 only in the C cycle; 0 for A, B, D.
   - reject=1 in the D cycle.
2. Interleaved load: A(load=1), a(load=0), B(1), b(0), C(1), c(0).
   - resolve=1 only in the C cycle; lowercase bytes are ignored.
3. Continuous load of A,B,X,C,A,B,C,A,B,C,A,B,A,B,A,B,C.
   - resolve=1 exactly at the 7th, 10th and 17th bytes.
   - No resolve after ABX or on a partial AB followed by A.
4. load=1 continuously with restart_n low in alternate cycles: A,B,C(rst),A,B(rst),C,A(rst),B,C.
   - resolve=0 on the first C (reset cycle forces 0).
   - resolve=0 on the second C (window is B only).
   - resolve=1 on the final C, because the A loaded during the reset cycle seeds the window.
5. L=1, Ref="Z", stream Y,Z,Z.
   - resolve=1 on both Z cycles.
   - reject=1 on Y.
6. restart_n=0 held with load=1 and A,B,C streamed.
   - resolve and reject stay 0 throughout.
